avr_prog_mem: RTL

Program-memory responder for the AVR core: it answers the fetch unit's word-address requests with 16-bit instruction words one cycle later. It also has a byte-wide loader port that streams a program image into the array while holding the CPU. It sits between the fetch unit (prog_addr → prog_data) and an external boot/loader source.

---
 rtl/avr_prog_mem_pkg.sv | 22 ++
 rtl/avr_prog_mem_if.sv | 27 ++
 rtl/avr_prog_mem_ram.sv | 25 ++
 rtl/avr_prog_mem.sv | 113 +++++++++++
 4 files changed

// File: rtl/avr_prog_mem_pkg.sv
// Shared types and constants for the AVR program-memory slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package avr_pkg;

    // Loader session states: idle, waiting low byte, waiting high byte, commit.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        WR   = 2'd3
    } state_t;

    // Word returned to fetch whenever the array must not be read.
    localparam logic [15:0] NOP_WORD = 16'h0000;

    // True when a 16-bit word address lands inside an array of 2**aw words.
    function automatic logic addr_in_array(input logic [15:0] a, input int aw);
        return (a >> aw) == 16'd0;
    endfunction

endpackage

// File: rtl/avr_prog_mem_if.sv
// Fetch and loader signal bundle between the core side and program memory.
// Latency: n/a (wires only).
// Backpressure: ld_ready from the memory side gates ld_valid/ld_byte.
interface avr_prog_mem_if;
    logic [15:0] prog_addr;
    logic [15:0] prog_data;
    logic        ld_start;
    logic [15:0] ld_addr;
    logic [7:0]  ld_byte;
    logic        ld_valid;
    logic        ld_ready;
    logic        ld_done;
    logic        cpu_hold;
    logic        ld_err;

    // Core/loader side: drives addresses and load bytes.
    modport master (
        output prog_addr, ld_start, ld_addr, ld_byte, ld_valid, ld_done,
        input  prog_data, ld_ready, cpu_hold, ld_err
    );

    // Memory side.
    modport slave (
        input  prog_addr, ld_start, ld_addr, ld_byte, ld_valid, ld_done,
        output prog_data, ld_ready, cpu_hold, ld_err
    );
endinterface

// File: rtl/avr_prog_mem_ram.sv
// DEPTH x 16 synchronous array, one write port and one read port, no reset.
// Latency: read data one cycle after the read address edge.
// Backpressure: none; accepts a write and a read every cycle.
module avr_prog_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              CLK,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [15:0]       i_wdat,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [15:0]       o_rdat
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [15:0] r_mem [DEPTH];

    // Plain write-then-registered-read so synthesis maps this onto block RAM.
    always_ff @(posedge CLK) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdat;
        end
        o_rdat <= r_mem[i_raddr];
    end
endmodule

// File: rtl/avr_prog_mem.sv
// Program memory for the AVR core: fetch reads plus a byte-wide image loader.
// Latency: prog_data one cycle after prog_addr; one loaded word per 3 cycles.
// Backpressure: ld_ready low outside LO/HI and whenever ld_done is asserted.
module avr_prog_mem
    import avr_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic           CLK,
    input  logic           RST,
    avr_prog_mem_if.slave  bus
);
    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_wptr;
    logic [7:0]          r_lo;
    logic [7:0]          r_hi;
    logic                r_err;
    logic                r_rd_vld;
    logic                w_ready;
    logic                w_hs;
    logic                w_we;
    logic [15:0]         w_ram_rdat;

    // ld_done outranks a simultaneous byte so a closing session never takes data.
    assign w_ready = ((r_state == LO) || (r_state == HI)) && !bus.ld_done;
    assign w_hs    = bus.ld_valid && w_ready;
    assign w_we    = (r_state == WR);

    assign bus.ld_ready = w_ready;
    assign bus.cpu_hold = (r_state != IDLE);
    assign bus.ld_err   = r_err;

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: collect two bytes, commit, repeat until ld_done.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (bus.ld_start) w_state_nxt = LO;
            LO: begin
                if (bus.ld_done)  w_state_nxt = IDLE;
                else if (w_hs)    w_state_nxt = HI;
            end
            HI: begin
                if (bus.ld_done)  w_state_nxt = IDLE;
                else if (w_hs)    w_state_nxt = WR;
            end
            WR:      w_state_nxt = LO;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Loader datapath: write pointer, byte latches and the sticky error flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wptr <= '0;
            r_lo   <= 8'h00;
            r_hi   <= 8'h00;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.ld_start) begin
                        // Out-of-range start still loads at the truncated address.
                        r_wptr <= bus.ld_addr[ADDR_W-1:0];
                        r_err  <= !addr_in_array(bus.ld_addr, ADDR_W);
                    end
                end
                LO: begin
                    if (w_hs) r_lo <= bus.ld_byte;
                end
                HI: begin
                    // Closing with only the low byte drops the partial word.
                    if (bus.ld_done)  r_err <= 1'b1;
                    else if (w_hs)    r_hi  <= bus.ld_byte;
                end
                WR: begin
                    if (r_wptr == '1) r_err <= 1'b1;
                    r_wptr <= r_wptr + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Remember whether this cycle's read may be shown to fetch; anything else is NOP.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rd_vld <= 1'b0;
        end else begin
            r_rd_vld <= (r_state == IDLE) && addr_in_array(bus.prog_addr, ADDR_W);
        end
    end

    assign bus.prog_data = r_rd_vld ? w_ram_rdat : NOP_WORD;

    avr_prog_ram #(.ADDR_W(ADDR_W)) u_ram (
        .CLK     (CLK),
        .i_we    (w_we),
        .i_waddr (r_wptr),
        .i_wdat  ({r_hi, r_lo}),
        .i_raddr (bus.prog_addr[ADDR_W-1:0]),
        .o_rdat  (w_ram_rdat)
    );
endmodule
